uart_rx_frame: RTL and testbench

Standalone 8N1 UART receiver: deserializes the line that the existing `tx` serializer drives, LSB first. It samples mid-bit, rejects start-bit glitches and flags stop-bit framing errors. Data is presented as a one-cycle valid pulse. It sits between the `uart_txd_in` pad and any byte consumer, and is also the checker end of `tx` in loopback benches.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_frame_sync2.sv | 28 ++
 rtl/uart_rx_frame.sv | 154 +++++++++++++++
 tb/tb_uart_rx_frame.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default baud
// constants that the rx and tx ends of the link both use.
package uart_pkg;

    // Default link setup: 100 MHz clock, 115200 baud.
    localparam int UART_CLOCKS_PER_BAUD = 868;
    localparam int UART_TIMER_BITS      = 32;

    // Frame payload width plus one (8 data bits -> 9).
    localparam int UART_BW              = 9;

    // Receiver states. ST_BREAK is only reachable when the break detector
    // is built in; otherwise it is simply never entered.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_t;

    // Timer load that lands the first sample in the middle of the start bit.
    function automatic int half_baud_load(input int clocks_per_baud);
        return clocks_per_baud / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_frame_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops load RESET_VAL on reset so the output starts at a known level.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk) begin
        if (srst) begin
            meta_reg <= RESET_VAL;
            q_reg    <= RESET_VAL;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, stop-bit
// framing error detection, one-cycle valid pulse on each good byte.
// Optional feature: define UART_RX_BREAK_EN to add the BREAK state and the
// o_break level output, which parks the receiver after a framing error until
// the line returns high. CLOCKS_PER_BAUD must be at least 4.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int BW              = UART_BW,
    parameter int TIMER_BITS      = UART_TIMER_BITS,
    parameter int CLOCKS_PER_BAUD = UART_CLOCKS_PER_BAUD
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_rx,
    output logic          o_valid,
    output logic [BW-2:0] o_data,
    output logic          o_frame_err
`ifdef UART_RX_BREAK_EN
    ,
    output logic          o_break
`endif
);

    localparam int DW = BW - 1;
    localparam int CW = $clog2(DW + 1);

    localparam logic [TIMER_BITS-1:0] TIMER_FULL = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
    localparam logic [TIMER_BITS-1:0] TIMER_HALF = TIMER_BITS'(half_baud_load(CLOCKS_PER_BAUD));
    localparam logic [CW-1:0]         CNT_LAST   = CW'(DW - 1);

    logic line;

    uart_rx_state_t          state_reg;
    logic [TIMER_BITS-1:0]   timer_reg;
    logic [CW-1:0]           bit_cnt_reg;
    logic [DW-1:0]           shreg_reg;
    logic [DW-1:0]           data_reg;
    logic                    valid_reg;
    logic                    ferr_reg;
`ifdef UART_RX_BREAK_EN
    logic                    break_reg;
`endif

    // Bring the pad into the clock domain; idle level is high.
    sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk  (clk),
        .srst (i_reset),
        .d    (i_rx),
        .q    (line)
    );

    // Frame FSM: bit timing, deserialization and the output pulses.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_reg   <= ST_IDLE;
            timer_reg   <= '0;
            bit_cnt_reg <= '0;
            shreg_reg   <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
`ifdef UART_RX_BREAK_EN
            break_reg   <= 1'b0;
`endif
        end else begin
            // Pulses last exactly one clock unless re-asserted below.
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    // Falling edge of a start bit: wait half a bit to centre.
                    if (!line) begin
                        timer_reg <= TIMER_HALF;
                        state_reg <= ST_START;
                    end
                end

                ST_START: begin
                    if (timer_reg != '0) begin
                        timer_reg <= timer_reg - 1'b1;
                    end else if (!line) begin
                        // Start bit still low at its centre: a real frame.
                        timer_reg   <= TIMER_FULL;
                        bit_cnt_reg <= '0;
                        state_reg   <= ST_DATA;
                    end else begin
                        // Line already back high: treat as a glitch.
                        state_reg <= ST_IDLE;
                    end
                end

                ST_DATA: begin
                    if (timer_reg != '0) begin
                        timer_reg <= timer_reg - 1'b1;
                    end else begin
                        // LSB arrives first, so shift in from the top.
                        shreg_reg   <= {line, shreg_reg[DW-1:1]};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        timer_reg   <= TIMER_FULL;
                        if (bit_cnt_reg == CNT_LAST) begin
                            state_reg <= ST_STOP;
                        end
                    end
                end

                ST_STOP: begin
                    if (timer_reg != '0) begin
                        timer_reg <= timer_reg - 1'b1;
                    end else if (line) begin
                        data_reg  <= shreg_reg;
                        valid_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        // Stop bit low: report it and keep the last good byte.
                        ferr_reg  <= 1'b1;
`ifdef UART_RX_BREAK_EN
                        break_reg <= 1'b1;
                        state_reg <= ST_BREAK;
`else
                        state_reg <= ST_IDLE;
`endif
                    end
                end

`ifdef UART_RX_BREAK_EN
                ST_BREAK: begin
                    // Park here while the line is held low so a long break
                    // does not look like a stream of bad frames.
                    if (line) begin
                        break_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
`endif

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_valid     = valid_reg;
    assign o_data      = data_reg;
    assign o_frame_err = ferr_reg;
`ifdef UART_RX_BREAK_EN
    assign o_break     = break_reg;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame with CLOCKS_PER_BAUD = 16.
// A line model drives 8N1 frames; a scoreboard of expected pulse events
// (cycle, kind, byte) derived from the frame timing rule is compared against
// the DUT outputs on every clock. Build with UART_RX_BREAK_EN to cover break.
`timescale 1ns/1ps
module tb_uart_rx_frame;

    localparam int CPB = 16;
    localparam int BW  = 9;
    localparam int DW  = 8;
    // Edge of the valid/frame-error pulse relative to T0.
    localparam int LAT = 2 + CPB / 2 + BW * CPB;

    logic          clk     = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_rx    = 1'b1;
    logic          o_valid;
    logic          o_frame_err;
    logic [DW-1:0] o_data;
`ifdef UART_RX_BREAK_EN
    logic          o_break;
`endif

    uart_rx_frame #(
        .BW              (BW),
        .TIMER_BITS      (32),
        .CLOCKS_PER_BAUD (CPB)
    ) dut (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_rx        (i_rx),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_frame_err (o_frame_err)
`ifdef UART_RX_BREAK_EN
        ,
        .o_break     (o_break)
`endif
    );

    always #5 clk = ~clk;

    // Edge counter: after edge k (and until edge k+1) cyc == k.
    int cyc = 0;
    bit rst_seen = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= i_reset;
    end

    typedef struct {
        int            cyc;
        bit            good;
        logic [DW-1:0] data;
    } ev_t;

    ev_t           exp_q[$];
    logic [DW-1:0] exp_data      = '0;
    bit            exp_brk       = 1'b0;
    int            brk_clear_cyc = -1;
    bit            ev_v;
    bit            ev_f;

    int            n_checks = 0;
    int            n_errors = 0;
    int            n_valid  = 0;
    int            n_ferr   = 0;
    int            last_valid_cyc = -1;
    int            last_ferr_cyc  = -1;
    logic [DW-1:0] last_data = '0;
    int            last_t0   = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
        end
    endfunction

    // Per-cycle compare of DUT outputs against the event scoreboard.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (rst_seen) begin
                exp_q.delete();
                exp_data = '0;
                exp_brk  = 1'b0;
            end
            ev_v = 1'b0;
            ev_f = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                if (exp_q[0].good) begin
                    ev_v     = 1'b1;
                    exp_data = exp_q[0].data;
                end else begin
                    ev_f = 1'b1;
`ifdef UART_RX_BREAK_EN
                    exp_brk = 1'b1;
`endif
                end
                void'(exp_q.pop_front());
            end
`ifdef UART_RX_BREAK_EN
            if (cyc == brk_clear_cyc) exp_brk = 1'b0;
            check("break", o_break, exp_brk);
`endif
            check("valid", o_valid, ev_v);
            check("frame_err", o_frame_err, ev_f);
            check("data", o_data, exp_data);
            if (o_valid === 1'b1) begin
                n_valid++;
                last_valid_cyc = cyc;
                last_data      = o_data;
            end
            if (o_frame_err === 1'b1) begin
                n_ferr++;
                last_ferr_cyc = cyc;
            end
        end
    end

    // All stimulus tasks are entered and left 1 time unit after an edge.
    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] b, input bit stop_ok, input int stop_len);
        ev_t e;
        int  t0;
        t0      = cyc + 1;
        last_t0 = t0;
        e.cyc   = t0 + LAT;
        e.good  = stop_ok;
        e.data  = b;
        exp_q.push_back(e);
        $display("frame byte=0x%02h stop=%0d t0=%0d pulse_expected_at=%0d", b, stop_ok, t0, e.cyc);
        i_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < DW; i++) begin
            i_rx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        i_rx = stop_ok;
        repeat (stop_len) @(posedge clk);
        #1;
        i_rx = 1'b1;
    endtask

    int t_a, v_first, nv0, nf0;
    logic [DW-1:0] rb;
    int gap;

    initial begin
        // Reset and reset values.
        repeat (4) @(posedge clk);
        #1;
        i_reset = 1'b0;
        check("rst_valid", o_valid, 0);
        check("rst_frame_err", o_frame_err, 0);
        check("rst_data", o_data, 0);
`ifdef UART_RX_BREAK_EN
        check("rst_break", o_break, 0);
`endif
        idle(10);

        // Single frame 0xA5.
        send_frame(8'hA5, 1'b1, CPB);
        t_a = last_t0;
        idle(20);
        $display("txn A5: valid at %0d (t0 %0d) data 0x%02h", last_valid_cyc, t_a, last_data);
        check("a5_latency", last_valid_cyc - t_a, 154);
        check("a5_data", last_data, 8'hA5);
        check("a5_count", n_valid, 1);
        check("a5_no_ferr", n_ferr, 0);

        // Back-to-back 0x00 then 0xFF with zero idle.
        send_frame(8'h00, 1'b1, CPB);
        send_frame(8'hFF, 1'b1, CPB);
        idle(20);
        v_first = last_valid_cyc;
        $display("txn b2b: second valid at %0d data 0x%02h", last_valid_cyc, last_data);
        check("b2b_count", n_valid, 3);
        check("b2b_spacing", last_valid_cyc - (last_t0 - 160 + 154), 160);
        check("b2b_data", last_data, 8'hFF);

        // 5-clock glitch, then 0x3C.
        nv0 = n_valid;
        nf0 = n_ferr;
        i_rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(30);
        $display("txn glitch: valid=%0d ferr=%0d", n_valid - nv0, n_ferr - nf0);
        check("glitch_no_valid", n_valid, nv0);
        check("glitch_no_ferr", n_ferr, nf0);
        send_frame(8'h3C, 1'b1, CPB);
        idle(20);
        check("after_glitch_data", last_data, 8'h3C);

        // 0x55 with stop bit low.
        nf0 = n_ferr;
`ifdef UART_RX_BREAK_EN
        send_frame(8'h55, 1'b0, 400);
        brk_clear_cyc = cyc + 3;
        idle(40);
        check("break_released", o_break, 0);
`else
        send_frame(8'h55, 1'b0, CPB);
        idle(40);
`endif
        $display("txn stop_err: ferr at %0d (t0 %0d) data 0x%02h", last_ferr_cyc, last_t0, o_data);
        check("ferr_count", n_ferr, nf0 + 1);
        check("ferr_latency", last_ferr_cyc - last_t0, 154);
        check("ferr_data_held", o_data, 8'h3C);
        send_frame(8'h81, 1'b1, CPB);
        idle(20);
        check("after_ferr_data", last_data, 8'h81);

        // Reset during data bit 4 of 0x12, then 0x34.
        nv0 = n_valid;
        i_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            i_rx = rb_bit(8'h12, i);
            repeat (CPB) @(posedge clk);
            #1;
        end
        i_rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        idle(200);
        $display("txn reset_mid_frame: pulses=%0d data 0x%02h", n_valid - nv0, o_data);
        check("reset_no_pulse", n_valid, nv0);
        check("reset_data_cleared", o_data, 0);
        send_frame(8'h34, 1'b1, CPB);
        idle(20);
        check("after_reset_data", last_data, 8'h34);
        check("after_reset_count", n_valid, nv0 + 1);

        // Random byte stream with random gaps, including zero gaps.
        nv0 = n_valid;
        nf0 = n_ferr;
        for (int k = 0; k < 256; k++) begin
            rb  = 8'($urandom_range(0, 255));
            gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
            idle(gap);
            send_frame(rb, 1'b1, CPB);
        end
        idle(200);
        check("rand_count", n_valid, nv0 + 256);
        check("rand_no_ferr", n_ferr, nf0);
        check("scoreboard_drained", exp_q.size(), 0);
        if (v_first < 0) check("b2b_seen", v_first, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    function automatic logic rb_bit(input logic [DW-1:0] b, input int i);
        return b[i];
    endfunction

endmodule
